// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

  localparam int I2S_DEFAULT_WIDTH = 16;

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } i2s_rx_state_t;

  typedef struct packed {
    logic [I2S_DEFAULT_WIDTH-1:0] left;
    logic [I2S_DEFAULT_WIDTH-1:0] right;
  } i2s_pair_t;

endpackage

// File: rtl/i2s_pin_sync.sv
// Synchronizes sclk/ws/sdata through matched flop chains and emits a registered
// one-clk bit strobe on each sclk rising edge, with ws/sdata sampled alongside it.
module i2s_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic ws_i,
  input  logic sdata_i,
  output logic strobe_o,
  output logic ws_o,
  output logic sdata_o
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ws_sync;
  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic                   r_sclk_prev;
  logic                   r_strobe;
  logic                   r_ws;
  logic                   r_sdata;
  logic                   w_sclk_s;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync  <= '0;
      r_ws_sync    <= '0;
      r_sdata_sync <= '0;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
      r_ws_sync    <= {r_ws_sync[SYNC_STAGES-2:0], ws_i};
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], sdata_i};
    end
  end

  // ws/sdata are captured on the same clk the edge is detected, so all three stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_prev <= 1'b0;
      r_strobe    <= 1'b0;
      r_ws        <= 1'b0;
      r_sdata     <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk_s;
      r_strobe    <= w_sclk_s & ~r_sclk_prev;
      r_ws        <= r_ws_sync[SYNC_STAGES-1];
      r_sdata     <= r_sdata_sync[SYNC_STAGES-1];
    end
  end

  assign strobe_o = r_strobe;
  assign ws_o     = r_ws;
  assign sdata_o  = r_sdata;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// Slave-mode Philips I2S receiver: deserializes stereo frames into {left,right} pairs
// on a valid/ready interface. Define I2S_RX_FRAME_CHECK_EN to add frame_err_o.
module i2s_rx_deserializer
  import i2s_pkg::*;
#(
  parameter int WIDTH       = I2S_DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk_i,
  input  logic             ws_i,
  input  logic             sdata_i,
  output logic [WIDTH-1:0] left_o,
  output logic [WIDTH-1:0] right_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o
`ifdef I2S_RX_FRAME_CHECK_EN
  ,
  output logic             frame_err_o
`endif
);

  // Counter saturates at WIDTH+1 so over-long words remain distinguishable from exact ones
  localparam int CW = $clog2(WIDTH + 2);

  i2s_rx_state_t    r_state, w_state_nxt;
  logic             r_ws_q, w_ws_q_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_left_hold, w_left_hold_nxt;
  logic [WIDTH-1:0] w_word;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_change;
  logic             w_load;
  logic             w_strobe;
  logic             w_ws;
  logic             w_sdata;
`ifdef I2S_RX_FRAME_CHECK_EN
  logic             w_frame_err;
`endif

  i2s_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk     (clk),
    .rst     (rst),
    .sclk_i  (sclk_i),
    .ws_i    (ws_i),
    .sdata_i (sdata_i),
    .strobe_o(w_strobe),
    .ws_o    (w_ws),
    .sdata_o (w_sdata)
  );

  assign w_change = w_ws ^ r_ws_q;

  always_comb begin
    w_word = r_shift;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_cnt == CW'(WIDTH - 1 - i)) w_word[i] = w_sdata;
    end
    w_cnt_inc = (r_cnt <= CW'(WIDTH)) ? r_cnt + CW'(1) : r_cnt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ws_q_nxt      = r_ws_q;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_left_hold_nxt = r_left_hold;
    w_load          = 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
    w_frame_err     = 1'b0;
`endif
    if (w_strobe) begin
      w_ws_q_nxt = w_ws;
      unique case (r_state)
        SYNC_WAIT: begin
          if (w_change && r_ws_q && !w_ws) begin
            w_state_nxt = RUN;
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
          end
        end
        RUN: begin
          if (w_change) begin
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
`ifdef I2S_RX_FRAME_CHECK_EN
            w_frame_err = (w_cnt_inc != CW'(WIDTH));
`endif
            if (!r_ws_q) w_left_hold_nxt = w_word;
            else         w_load          = 1'b1;
          end else begin
            w_shift_nxt = w_word;
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        default: w_state_nxt = SYNC_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= SYNC_WAIT;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ws_q      <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_left_hold <= '0;
    end else begin
      r_ws_q      <= w_ws_q_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_left_hold <= w_left_hold_nxt;
    end
  end

  // A load always wins over the acceptance drop; it overruns only if the old pair was not taken
  always_ff @(posedge clk) begin
    if (rst) begin
      left_o    <= '0;
      right_o   <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (w_load) begin
        left_o    <= r_left_hold;
        right_o   <= w_word;
        valid_o   <= 1'b1;
        overrun_o <= valid_o && !ready_i;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) frame_err_o <= 1'b0;
    else     frame_err_o <= w_frame_err;
  end
`endif

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed + random bench for i2s_rx_deserializer with an I2S master BFM and pair scoreboard.
module tb_i2s_rx_deserializer;
  import i2s_pkg::*;

  localparam int WIDTH = 16;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sclk_i = 1'b0;
  logic             ws_i = 1'b0;
  logic             sdata_i = 1'b0;
  logic [WIDTH-1:0] left_o;
  logic [WIDTH-1:0] right_o;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic             overrun_o;
`ifdef I2S_RX_FRAME_CHECK_EN
  logic             frame_err_o;
`endif

  int errors = 0;
  int checks = 0;
  int n_accept = 0;
  int n_overrun = 0;
  int n_ferr = 0;
  int hp = 4;
  int base_acc;
  int base_ovr;
  bit done;
  i2s_pair_t sb[$];
  i2s_pair_t mon_exp;

  i2s_rx_deserializer #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sclk_i(sclk_i),
    .ws_i(ws_i),
    .sdata_i(sdata_i),
    .left_o(left_o),
    .right_o(right_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .overrun_o(overrun_o)
`ifdef I2S_RX_FRAME_CHECK_EN
    ,
    .frame_err_o(frame_err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] trunc(input logic [31:0] d, input int len);
    logic [31:0] t;
    if (len >= 16) t = d >> (len - 16);
    else           t = d << (16 - len);
    return t[15:0];
  endfunction

  // Data and ws change on the sclk falling edge; optional latency probe after the rising edge.
  task automatic send_bit(input logic ws, input logic d, input bit measure);
    ws_i = ws;
    sdata_i = d;
    repeat (hp) @(posedge clk);
    #2 sclk_i = 1'b1;
    if (measure) begin
      repeat (SYNC + 1) @(posedge clk);
      #1 check("latency_before", valid_o, 1'b0);
      @(posedge clk);
      #1 check("latency_at", valid_o, 1'b1);
      #1;
    end else begin
      repeat (hp) @(posedge clk);
      #2;
    end
    sclk_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input int len, input logic ws_body, input bit measure);
    for (int i = len - 1; i >= 0; i--)
      send_bit((i == 0) ? ~ws_body : ws_body, d[i], measure && (i == 0));
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int len, input bit measure);
    send_word(l, len, 1'b0, 1'b0);
    send_word(r, len, 1'b1, measure);
  endtask

  task automatic push_pair(input logic [31:0] l, input logic [31:0] r, input int len);
    i2s_pair_t p;
    p.left  = trunc(l, len);
    p.right = trunc(r, len);
    sb.push_back(p);
  endtask

  task automatic preamble();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (20) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (overrun_o) begin
        n_overrun++;
        check("overrun_pending", sb.size() != 0, 1'b1);
        if (sb.size() != 0) void'(sb.pop_front());
      end
      if (valid_o && ready_i) begin
        n_accept++;
        check("accept_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          check("left_o", left_o, mon_exp.left);
          check("right_o", right_o, mon_exp.right);
        end
      end
`ifdef I2S_RX_FRAME_CHECK_EN
      if (frame_err_o) n_ferr++;
`endif
    end
  end

  initial begin
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_left", left_o, 16'h0);
    check("rst_right", right_o, 16'h0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_overrun", overrun_o, 1'b0);

    // 1: single frame, ready high, latency probe on the right LSB
    preamble();
    base_acc = n_accept;
    push_pair(32'hA5C3, 32'h1234, 16);
    send_frame(32'hA5C3, 32'h1234, 16, 1'b1);
    drain();
    check("t1_accepts", n_accept - base_acc, 1);
    check("t1_overruns", n_overrun, 0);

    // 2: overrun while stalled
    ready_i = 1'b0;
    push_pair(32'h1111, 32'h2222, 16);
    send_frame(32'h1111, 32'h2222, 16, 1'b0);
    push_pair(32'h3333, 32'h4444, 16);
    send_frame(32'h3333, 32'h4444, 16, 1'b0);
    drain();
    check("t2_overruns", n_overrun, 1);
    check("t2_valid_held", valid_o, 1'b1);
    check("t2_left", left_o, 16'h3333);
    check("t2_right", right_o, 16'h4444);
    @(posedge clk);
    #1 ready_i = 1'b1;
    @(posedge clk);
    #1 check("t2_valid_drop", valid_o, 1'b0);
    check("t2_sb_empty", sb.size(), 0);
`ifdef I2S_RX_FRAME_CHECK_EN
    check("t2_no_ferr", n_ferr, 0);
`endif

    // 3: release reset mid right channel carrying garbage
    rst = 1'b1;
    sb.delete();
    base_acc = n_accept;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'($urandom), 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'($urandom), 1'b0);
    send_bit(1'b0, 1'($urandom), 1'b0);
    drain();
    check("t3_no_early_valid", valid_o, 1'b0);
    push_pair(32'hBEEF, 32'hC0DE, 16);
    send_frame(32'hBEEF, 32'hC0DE, 16, 1'b0);
    drain();
    check("t3_accepts", n_accept - base_acc, 1);

    // 4: long and short words
    push_pair(32'h2ABCD, 32'h15555, 18);
    send_frame(32'h2ABCD, 32'h15555, 18, 1'b0);
    push_pair(32'h3FFF, 32'h1234, 14);
    send_frame(32'h3FFF, 32'h1234, 14, 1'b0);
    push_pair(32'h0F0F, 32'hF0F0, 16);
    send_frame(32'h0F0F, 32'hF0F0, 16, 1'b0);
    drain();
    check("t4_sb_empty", sb.size(), 0);
`ifdef I2S_RX_FRAME_CHECK_EN
    check("t4_ferr_count", n_ferr, 4);
`endif

    // 5: one-clk reset mid-frame while a pair is pending
    ready_i = 1'b0;
    push_pair(32'h5555, 32'h6666, 16);
    send_frame(32'h5555, 32'h6666, 16, 1'b0);
    drain();
    check("t5_valid_before", valid_o, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'($urandom), 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("t5_valid_cleared", valid_o, 1'b0);
    check("t5_left_cleared", left_o, 16'h0);
    check("t5_right_cleared", right_o, 16'h0);
    sb.delete();
    ready_i = 1'b1;
    base_acc = n_accept;
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom), 1'b0);
    send_bit(1'b1, 1'($urandom), 1'b0);
    for (int i = 0; i < 15; i++) send_bit(1'b1, 1'($urandom), 1'b0);
    send_bit(1'b0, 1'($urandom), 1'b0);
    drain();
    check("t5_no_garbage", n_accept - base_acc, 0);
    push_pair(32'h7777, 32'h8888, 16);
    send_frame(32'h7777, 32'h8888, 16, 1'b0);
    drain();
    check("t5_accepts", n_accept - base_acc, 1);

    // 6: clk = 4*sclk, random frames and random ready
    hp = 2;
    done = 1'b0;
    base_acc = n_accept;
    base_ovr = n_overrun;
    fork
      begin
        for (int f = 0; f < 100; f++) begin
          logic [31:0] l;
          logic [31:0] r;
          l = {16'h0, 16'($urandom)};
          r = {16'h0, 16'($urandom)};
          push_pair(l, r, 16);
          send_frame(l, r, 16, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 ready_i = ($urandom_range(0, 149) == 0);
        end
      end
    join
    ready_i = 1'b1;
    drain();
    check("t6_sb_empty", sb.size(), 0);
    check("t6_all_resolved", (n_accept - base_acc) + (n_overrun - base_ovr), 100);
    check("t6_valid_idle", valid_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
